// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared types and constants for the instruction prefetch queue.
//   - fetchq_state_t : prefetch control states (RESET / RUN / HALTED)
//   - NOP_INST       : instruction presented to decode when the queue is empty
//   - fetch_entry_t  : one buffered instruction tagged with its PC (96 bits)
//   - pc_next()      : sequential fetch address increment (wraps modulo 2^64)
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetchq_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [63:0] pc_next(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   DEPTH x 96-bit instruction buffer. Occupancy is tracked by the parent, so
//   this block only owns the storage and the two wrapping pointers.
//   Ports:
//     clk_i, rst_ni   : clock, asynchronous active-low reset (pointers only)
//     wr_en_i         : write wr_data_i at the write pointer
//     wr_data_i       : {pc, inst} entry
//     rd_en_i         : advance the read pointer (head consumed)
//     flush_i         : discard everything; read pointer catches up to write
//     head_o          : entry at the read pointer, read from storage registers
//                       (a write at edge N is visible after edge N, no bypass)
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  fetch_entry_t wr_data_i,
  input  logic         rd_en_i,
  input  logic         flush_i,
  output fetch_entry_t head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  fetch_entry_t     mem_q [DEPTH];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Flush empties the buffer by pointer equality; any same-cycle write is
    // wrong-path and must not become visible either.
    if (flush_i) rd_ptr_d = wr_ptr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the parent's count qualifies the head, so stale data is never used.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o = mem_q[rd_ptr_q];

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction prefetch stage. Issues sequential 32-bit fetches to a
//   variable-latency, in-order instruction memory, buffers the responses with
//   their PCs, and hands them to decode over a valid/ready handshake. A taken
//   redirect flushes the buffer and discards responses still in flight.
//   Ports:
//     clk_i, rst_ni             : clock, asynchronous active-low reset
//     redirect_valid_i/_pc_i    : taken jump/branch; refetch from redirect_pc_i
//     halt_i                    : stop issuing; buffered entries still drain
//     req_valid_o/addr_o/ready_i: fetch request channel
//     resp_valid_i/inst_i       : in-order fetch responses
//     inst_valid_o/inst_o/pc_o  : head of queue to decode (NOP / 0 when empty)
//     inst_ready_i              : decode accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        req_valid_o,
  output logic [63:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_inst_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

  fetchq_state_t  state_q, state_d;
  logic [63:0]    fetch_pc_q, fetch_pc_d;
  logic [63:0]    resp_pc_q, resp_pc_d;
  cnt_t           count_q, count_d;
  cnt_t           inflight_q, inflight_d;
  cnt_t           drop_q, drop_d;

  logic           req_fire;
  logic           resp_keep;
  logic           deq;
  logic           has_credit;
  logic [CNT_W:0] occupancy;
  fetch_entry_t   wr_entry;
  fetch_entry_t   head;

  // Credit: a request only goes out if its response is guaranteed a slot, so
  // responses never need back-pressure.
  assign occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
  assign has_credit = occupancy < CREDIT_LIMIT;

  assign req_valid_o = (state_q == ST_RUN) && !redirect_valid_i && has_credit;
  assign req_addr_o  = fetch_pc_q;
  assign req_fire    = req_valid_o && req_ready_i;

  // A response arriving with a redirect belongs to the old path.
  assign resp_keep = resp_valid_i && !redirect_valid_i && (drop_q == '0);

  assign inst_valid_o = (count_q != '0);
  assign deq          = inst_valid_o && inst_ready_i;
  assign inst_o       = inst_valid_o ? head.inst : NOP_INST;
  assign inst_pc_o    = inst_valid_o ? head.pc   : 64'h0;

  assign wr_entry = '{pc: resp_pc_q, inst: resp_inst_i};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (resp_keep),
    .wr_data_i (wr_entry),
    .rd_en_i   (deq),
    .flush_i   (redirect_valid_i),
    .head_o    (head)
  );

  // Control FSM: leaves RESET on the first clock, halts on request, and only
  // a redirect without halt resumes fetching.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_RUN;
      ST_RUN:    if (halt_i) state_d = ST_HALTED;
      ST_HALTED: if (redirect_valid_i && !halt_i) state_d = ST_RUN;
      default:   state_d = ST_RESET;
    endcase
  end

  // Counters and PCs; redirect overrides everything else.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q + cnt_t'(resp_keep) - cnt_t'(deq);
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(resp_valid_i);
    drop_d     = drop_q;

    if (req_fire)  fetch_pc_d = pc_next(fetch_pc_q);
    if (resp_keep) resp_pc_d  = pc_next(resp_pc_q);
    if (resp_valid_i && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);

    if (redirect_valid_i) begin
      count_d    = '0;
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      // No request issues this cycle, so what remains in flight after this
      // cycle's response retires is exactly what must be discarded.
      drop_d     = inflight_q - cnt_t'(resp_valid_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed test of fetch_queue (DEPTH=4, RESET_PC=0) against an in-order
//   instruction memory model with programmable latency. Inputs change on the
//   falling edge; outputs are sampled on the falling edge before new inputs.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        halt_i;
  logic        req_valid_o;
  logic [63:0] req_addr_o;
  logic        req_ready_i;
  logic        resp_valid_i;
  logic [31:0] resp_inst_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_ready_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .halt_i           (halt_i),
    .req_valid_o      (req_valid_o),
    .req_addr_o       (req_addr_o),
    .req_ready_i      (req_ready_i),
    .resp_valid_i     (resp_valid_i),
    .resp_inst_i      (resp_inst_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_ready_i     (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Instruction word stored at an address in the memory model.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend[$];
  int unsigned cyc       = 0;
  int unsigned lat       = 1;
  int unsigned reqs_seen = 0;

  // Accept handshakes and retire responses at the rising edge; reset with the DUT.
  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        pend.delete();
        reqs_seen = 0;
      end else begin
        if (resp_valid_i && pend.size() > 0) void'(pend.pop_front());
        if (req_valid_o && req_ready_i) begin
          pend.push_back('{addr: req_addr_o, due: cyc + lat});
          reqs_seen++;
        end
        cyc++;
      end
    end
  end

  // Present the oldest response once its latency has elapsed.
  initial begin
    resp_valid_i = 1'b0;
    resp_inst_i  = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && pend.size() > 0 && pend[0].due <= cyc) begin
        resp_valid_i = 1'b1;
        resp_inst_i  = inst_of(pend[0].addr);
      end else begin
        resp_valid_i = 1'b0;
        resp_inst_i  = '0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni           = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    halt_i           = 1'b0;
    inst_ready_i     = 1'b0;
    req_ready_i      = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_valid"},  req_valid_o,  64'd0);
    check({pfx, "_req_addr"},   req_addr_o,   64'h0);
    check({pfx, "_inst_valid"}, inst_valid_o, 64'd0);
    check({pfx, "_inst"},       inst_o,       64'(NOP_INST));
    check({pfx, "_inst_pc"},    inst_pc_o,    64'h0);
  endtask

  initial begin
    rst_ni           = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    halt_i           = 1'b0;
    req_ready_i      = 1'b1;
    inst_ready_i     = 1'b0;

    // ---- 1: reset values, then streaming with 1-cycle memory ----
    repeat (2) @(negedge clk_i);
    check_reset_outputs("t1_rst");
    lat = 1;
    do_reset();
    inst_ready_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_i);
      check($sformatf("t1_req_valid[%0d]", k), req_valid_o, 64'd1);
      check($sformatf("t1_req_addr[%0d]", k), req_addr_o, 64'(4 * (k - 1)));
      if (k >= 3) begin
        check($sformatf("t1_inst_valid[%0d]", k), inst_valid_o, 64'd1);
        check($sformatf("t1_inst_pc[%0d]", k), inst_pc_o, 64'(4 * (k - 3)));
        check($sformatf("t1_inst[%0d]", k), inst_o, 64'(inst_of(64'(4 * (k - 3)))));
      end else begin
        check($sformatf("t1_inst_valid[%0d]", k), inst_valid_o, 64'd0);
      end
    end

    // ---- 2: decode stalled, queue fills to DEPTH then drains in order ----
    lat = 1;
    do_reset();
    repeat (8) @(negedge clk_i);
    check("t2_reqs_issued", 64'(reqs_seen), 64'd4);
    check("t2_req_valid_full", req_valid_o, 64'd0);
    check("t2_inst_valid_full", inst_valid_o, 64'd1);
    check("t2_head0", inst_pc_o, 64'h0);
    inst_ready_i = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk_i);
      check($sformatf("t2_inst_valid[%0d]", j), inst_valid_o, 64'd1);
      check($sformatf("t2_head_pc[%0d]", j), inst_pc_o, 64'(4 * j));
      if (j == 1) begin
        check("t2_resume_valid", req_valid_o, 64'd1);
        check("t2_resume_addr", req_addr_o, 64'h10);
      end
    end

    // ---- 3: 3-cycle memory, redirect with two requests in flight ----
    lat = 3;
    do_reset();
    inst_ready_i = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk_i);
      check($sformatf("t3_req_addr[%0d]", k), req_addr_o, 64'(4 * (k - 1)));
    end
    @(negedge clk_i);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h100;
    #1;
    check("t3_no_req_in_redirect", req_valid_o, 64'd0);
    @(negedge clk_i);
    redirect_valid_i = 1'b0;
    #1;
    check("t3_req_valid_after", req_valid_o, 64'd1);
    check("t3_req_addr_after", req_addr_o, 64'h100);
    for (int k = 4; k <= 7; k++) begin
      if (k > 4) @(negedge clk_i);
      check($sformatf("t3_empty[%0d]", k), inst_valid_o, 64'd0);
    end
    @(negedge clk_i);
    check("t3_head_valid", inst_valid_o, 64'd1);
    check("t3_head_pc", inst_pc_o, 64'h100);
    check("t3_head_inst", inst_o, 64'(inst_of(64'h100)));
    @(negedge clk_i);
    check("t3_next_pc", inst_pc_o, 64'h104);

    // ---- 4: redirect coinciding with a response and a dequeue ----
    lat = 1;
    do_reset();
    inst_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("t4_head_before", inst_pc_o, 64'h0);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h200;
    @(negedge clk_i);
    redirect_valid_i = 1'b0;
    #1;
    check("t4_empty_after", inst_valid_o, 64'd0);
    check("t4_empty_pc", inst_pc_o, 64'h0);
    check("t4_reqs_issued", 64'(reqs_seen), 64'd2);
    check("t4_req_valid", req_valid_o, 64'd1);
    check("t4_req_addr", req_addr_o, 64'h200);
    @(negedge clk_i);
    check("t4_still_empty", inst_valid_o, 64'd0);
    @(negedge clk_i);
    check("t4_head_valid", inst_valid_o, 64'd1);
    check("t4_head_pc", inst_pc_o, 64'h200);

    // ---- 5: halt with two entries buffered, then redirects out of HALTED ----
    lat = 1;
    do_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    halt_i = 1'b1;
    #1;
    check("t5_req_in_halt_cycle", req_valid_o, 64'd1);
    check("t5_req_addr_halt_cycle", req_addr_o, 64'h4);
    @(negedge clk_i);
    check("t5_req_stopped", req_valid_o, 64'd0);
    @(negedge clk_i);
    check("t5_buffered_valid", inst_valid_o, 64'd1);
    check("t5_buffered_head", inst_pc_o, 64'h0);
    check("t5_reqs_issued", 64'(reqs_seen), 64'd2);
    inst_ready_i = 1'b1;
    @(negedge clk_i);
    check("t5_drain_valid", inst_valid_o, 64'd1);
    check("t5_drain_pc", inst_pc_o, 64'h4);
    for (int k = 6; k <= 8; k++) begin
      @(negedge clk_i);
      check($sformatf("t5_drained_valid[%0d]", k), inst_valid_o, 64'd0);
      check($sformatf("t5_drained_inst[%0d]", k), inst_o, 64'(NOP_INST));
      check($sformatf("t5_halted_req[%0d]", k), req_valid_o, 64'd0);
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h280;
    @(negedge clk_i);
    redirect_valid_i = 1'b0;
    #1;
    check("t5_stay_halted", req_valid_o, 64'd0);
    check("t5_halted_redirect_addr", req_addr_o, 64'h280);
    @(negedge clk_i);
    halt_i           = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h300;
    @(negedge clk_i);
    redirect_valid_i = 1'b0;
    #1;
    check("t5_resume_valid", req_valid_o, 64'd1);
    check("t5_resume_addr", req_addr_o, 64'h300);
    repeat (2) @(negedge clk_i);
    check("t5_resume_head", inst_pc_o, 64'h300);

    // ---- 6: asynchronous reset mid-stream with the queue half full ----
    lat = 1;
    do_reset();
    repeat (4) @(negedge clk_i);
    check("t6_half_full", inst_valid_o, 64'd1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(negedge clk_i);
    rst_ni       = 1'b1;
    inst_ready_i = 1'b1;
    @(negedge clk_i);
    check("t6_refetch_valid", req_valid_o, 64'd1);
    check("t6_refetch_addr", req_addr_o, 64'h0);
    @(negedge clk_i);
    check("t6_refetch_addr2", req_addr_o, 64'h4);
    @(negedge clk_i);
    check("t6_refetch_head", inst_pc_o, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_fetch_queue
